// File: rtl/imem_loader_ctrl_if.sv
// rtl/imem_loader_ctrl_if.sv - byte stream and imem write port bundle for the loader
// slave is the loader side, master is the stream source / memory side.
interface imem_loader_ctrl_if #(
  parameter int unsigned ADDR_W = 29
) ();
  logic [7:0]        byte_data_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;

  modport slave (
    input  byte_data_i,
    input  byte_valid_i,
    output byte_ready_o,
    output imem_we_o,
    output imem_addr_o,
    output imem_wdata_o
  );

  modport master (
    output byte_data_i,
    output byte_valid_i,
    input  byte_ready_o,
    input  imem_we_o,
    input  imem_addr_o,
    input  imem_wdata_o
  );
endinterface

// File: rtl/imem_loader_ctrl.sv
// rtl/imem_loader_ctrl.sv - boot loader filling imem from a byte stream
// Takes a 4-byte LE word count, then LE program words; holds the core in reset until success.
module imem_loader_ctrl #(
  parameter int unsigned ADDR_W    = 29,
  parameter int unsigned DEPTH     = 8192,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  imem_loader_ctrl_if.slave  bus,
  output logic               core_rst_no,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] MAX_LEN = 32'(DEPTH - BASE_ADDR);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]        r_byte_idx;
  logic [31:0]       r_len;
  logic [31:0]       r_word_cnt;
  logic [23:0]       r_word;
  logic [IDLE_W-1:0] r_idle;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_err;
  logic              r_core_rst_n;

  logic        w_ready;
  logic        w_xfer;
  logic        w_last_byte;
  logic        w_timeout;
  logic        w_start;
  logic [31:0] w_len_full;
  logic [31:0] w_cnt_next;
  logic [31:0] w_addr_full;

  assign w_ready     = (r_state == S_LEN) || (r_state == S_DATA);
  assign w_xfer      = w_ready && bus.byte_valid_i;
  assign w_last_byte = (r_byte_idx == 2'd3);
  // Timeout fires on the cycle the idle count would reach TIMEOUT.
  assign w_timeout   = w_ready && !bus.byte_valid_i && (r_idle == IDLE_LAST);
  assign w_start     = start_i &&
                       ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_len_full  = {bus.byte_data_i, r_len[23:0]};
  assign w_cnt_next  = r_word_cnt + 32'd1;
  assign w_addr_full = 32'(BASE_ADDR) + r_word_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_start) begin
          w_next = S_LEN;
        end
      end
      S_LEN: begin
        if (w_timeout) begin
          w_next = S_ERR;
        end else if (w_xfer && w_last_byte) begin
          if (w_len_full == 32'd0) begin
            w_next = S_DONE;
          end else if (w_len_full > MAX_LEN) begin
            w_next = S_ERR;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_timeout) begin
          w_next = S_ERR;
        end else if (w_xfer && w_last_byte) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_cnt_next == r_len) begin
          w_next = S_DONE;
        end else begin
          w_next = S_DATA;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_byte_idx   <= 2'd0;
      r_len        <= 32'd0;
      r_word_cnt   <= 32'd0;
      r_word       <= 24'd0;
      r_idle       <= '0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      if (w_start) begin
        r_byte_idx   <= 2'd0;
        r_len        <= 32'd0;
        r_word_cnt   <= 32'd0;
        r_idle       <= '0;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
        r_core_rst_n <= 1'b0;
      end
      if (w_ready) begin
        if (w_xfer) begin
          r_idle     <= '0;
          r_byte_idx <= r_byte_idx + 2'd1;
          if (r_state == S_LEN) begin
            r_len[{r_byte_idx, 3'b000} +: 8] <= bus.byte_data_i;
          end else if (!w_last_byte) begin
            r_word[{r_byte_idx, 3'b000} +: 8] <= bus.byte_data_i;
          end
        end else begin
          r_idle <= r_idle + IDLE_W'(1);
        end
      end
      // Write port registers only move when a complete word is ready, so they hold otherwise.
      if ((r_state == S_DATA) && w_xfer && w_last_byte) begin
        r_addr  <= ADDR_W'(w_addr_full);
        r_wdata <= {bus.byte_data_i, r_word};
      end
      if (r_state == S_WRITE) begin
        r_word_cnt <= w_cnt_next;
      end
      if ((w_next == S_DONE) && (r_state != S_DONE)) begin
        r_done       <= 1'b1;
        r_core_rst_n <= 1'b1;
      end
      if ((w_next == S_ERR) && (r_state != S_ERR)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.byte_ready_o = w_ready;
  assign bus.imem_we_o    = (r_state == S_WRITE);
  assign bus.imem_addr_o  = r_addr;
  assign bus.imem_wdata_o = r_wdata;
  assign busy_o           = w_ready || (r_state == S_WRITE);
  assign done_o           = r_done;
  assign err_o            = r_err;
  assign core_rst_no      = r_core_rst_n;

endmodule
